// File: rtl/rx_module.sv
// rx_module: RS232 8N1 serial receiver with a receive FIFO.
// Samples the synchronized line at mid-bit, writes accepted bytes into a
// FIFO_DEPTH-entry FIFO and lets the host pop them with rd_req.
// Optional even-parity checking is enabled by defining RX_MODULE_PARITY_EN.
module rx_module #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  input  logic                          rd_req,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          rx_busy
`ifdef RX_MODULE_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_MODULE_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t                 state, state_next;
  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [TW-1:0]          timer;
  logic                   tick;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   load_half, load_full, shift_en, byte_ok, stop_bad;
  logic                   wr_pend;
  logic                   wr_ok, rd_ok;
  logic [AW-1:0]          wptr, rptr;
  logic [CW-1:0]          count_next;
  logic [7:0]             mem [FIFO_DEPTH];
`ifdef RX_MODULE_PARITY_EN
  logic                   par_chk, par_fail;
`endif

  // Reset: assert asynchronously, release on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Input synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end
  assign rxs = sync[SYNC_STAGES-1];

  assign tick    = (timer == '0);
  assign rx_busy = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    byte_ok    = 1'b0;
    stop_bad   = 1'b0;
`ifdef RX_MODULE_PARITY_EN
    par_chk    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          load_half  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            load_full  = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
`ifdef RX_MODULE_PARITY_EN
          if (bit_idx == 3'd7) state_next = PARITY;
`else
          if (bit_idx == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef RX_MODULE_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_chk    = 1'b1;
          load_full  = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rxs) begin
`ifdef RX_MODULE_PARITY_EN
            byte_ok    = !par_fail;
`else
            byte_ok    = 1'b1;
`endif
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer, bit index and status pulses from the receive side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      bit_idx   <= 3'd0;
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_half)      timer <= HALF_LD;
      else if (load_full) timer <= FULL_LD;
      else if (!tick)     timer <= timer - 1'b1;
      if (state == START) bit_idx <= 3'd0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
      wr_pend   <= byte_ok;
      frame_err <= stop_bad;
    end
  end

`ifdef RX_MODULE_PARITY_EN
  // Even-parity check of the received byte against the parity bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_fail   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_chk && ((^shreg) != rxs);
      if (state == START) par_fail <= 1'b0;
      else if (par_chk)   par_fail <= ((^shreg) != rxs);
    end
  end
`endif

  // Shift register, LSB arrives first
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rxs, shreg[7:1]};
  end

  // Full check uses pre-read occupancy, so a same-cycle read never rescues a write
  assign wr_ok      = wr_pend && !fifo_full;
  assign rd_ok      = rd_req && !fifo_empty;
  assign count_next = fifo_count + CW'(wr_ok) - CW'(rd_ok);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= shreg;
  end

  // FIFO pointers, occupancy flags and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr    <= rptr + 1'b1;
        rx_data <= mem[rptr];
      end
      rx_valid   <= rd_ok;
      overrun    <= wr_pend && fifo_full;
      fifo_count <= count_next;
      fifo_empty <= (count_next == '0);
      fifo_full  <= (count_next == CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_rx_module.sv
// tb_rx_module: directed bench for rx_module (CLKS_PER_BIT=434, FIFO_DEPTH=4).
// Drives and samples on the falling clock edge.
module tb_rx_module;

  localparam int CPB   = 434;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       rd_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;
`ifdef RX_MODULE_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         perr_n = 0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ferr_n    = 0;
  int ovr_n     = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    logic       exp_full;
    int         exp_ovr;
  } vec_t;
  vec_t tbl [7];

  rx_module #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .rd_req     (rd_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
`ifdef RX_MODULE_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #10 clk = ~clk;

  // Count status pulses
  always @(negedge clk) begin
    if (frame_err) ferr_n <= ferr_n + 1;
    if (overrun)   ovr_n  <= ovr_n + 1;
`ifdef RX_MODULE_PARITY_EN
    if (parity_err) perr_n <= perr_n + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic send_bits(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    send_bits(1'b1, n);
  endtask

  // Full frame; the line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_n);
    send_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bits(d[i], CPB);
`ifdef RX_MODULE_PARITY_EN
    send_bits((^d) ^ par_flip, CPB);
`endif
    send_bits(stop_v, stop_n * CPB);
  endtask

  task automatic pop(input logic [7:0] exp, input string nm);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check({nm, " rx_valid"}, 32'(rx_valid), 32'd1);
    check({nm, " rx_data"}, 32'(rx_data), 32'(exp));
    @(negedge clk);
    check({nm, " rx_valid pulse end"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    int base;
    int k;
    tbl[0] = '{8'h55, 1, 1'b0, 0};
    tbl[1] = '{8'hA3, 2, 1'b0, 0};
    tbl[2] = '{8'h01, 1, 1'b0, 0};
    tbl[3] = '{8'h02, 2, 1'b0, 0};
    tbl[4] = '{8'h03, 3, 1'b0, 0};
    tbl[5] = '{8'h04, 4, 1'b1, 0};
    tbl[6] = '{8'h05, 4, 1'b1, 1};

    rx = 1'b1; rd_req = 1'b0; reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset rx_data",    32'(rx_data),    32'd0);
    check("reset rx_valid",   32'(rx_valid),   32'd0);
    check("reset fifo_empty", 32'(fifo_empty), 32'd1);
    check("reset fifo_full",  32'(fifo_full),  32'd0);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset frame_err",  32'(frame_err),  32'd0);
    check("reset overrun",    32'(overrun),    32'd0);
    check("reset rx_busy",    32'(rx_busy),    32'd0);
    reset_n = 1'b1;
    idle(CPB);

    // Two frames, then read them back
    base = ovr_n;
    for (int i = 0; i < 2; i++) begin
      send_frame(tbl[i].data, 1'b1, 1);
      check($sformatf("vec%0d count", i), 32'(fifo_count), 32'(tbl[i].exp_count));
      check($sformatf("vec%0d full", i),  32'(fifo_full),  32'(tbl[i].exp_full));
      check($sformatf("vec%0d overrun", i), 32'(ovr_n - base), 32'(tbl[i].exp_ovr));
    end
    idle(CPB);
    pop(8'h55, "pop 0x55");
    pop(8'hA3, "pop 0xA3");
    check("drained empty", 32'(fifo_empty), 32'd1);
    check("drained count", 32'(fifo_count), 32'd0);

    // Short low glitch is rejected as a false start
    base = ferr_n;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch busy", 32'(rx_busy), 32'd1);
    repeat (50) @(negedge clk);
    rx = 1'b1;
    k = 0;
    while (rx_busy && k < CPB / 2 + SS) begin
      @(negedge clk);
      k++;
    end
    check("glitch back to idle", 32'(rx_busy), 32'd0);
    check("glitch count", 32'(fifo_count), 32'd0);
    check("glitch frame_err", 32'(ferr_n - base), 32'd0);
    idle(CPB);

    // Stop bit held low: one frame error, then line break until high
    base = ferr_n;
    send_frame(8'h3C, 1'b0, 2);
    check("break busy", 32'(rx_busy), 32'd1);
    check("break frame_err", 32'(ferr_n - base), 32'd1);
    check("break count", 32'(fifo_count), 32'd0);
    idle(CPB);
    check("break single pulse", 32'(ferr_n - base), 32'd1);
    check("break idle", 32'(rx_busy), 32'd0);
    send_frame(8'h11, 1'b1, 1);
    check("after break count", 32'(fifo_count), 32'd1);
    idle(CPB);
    pop(8'h11, "pop 0x11");

    // Back-to-back frames overfill the FIFO
    base = ovr_n;
    for (int i = 2; i < 7; i++) begin
      send_frame(tbl[i].data, 1'b1, 1);
      check($sformatf("vec%0d count", i), 32'(fifo_count), 32'(tbl[i].exp_count));
      check($sformatf("vec%0d full", i),  32'(fifo_full),  32'(tbl[i].exp_full));
      check($sformatf("vec%0d overrun", i), 32'(ovr_n - base), 32'(tbl[i].exp_ovr));
    end
    idle(CPB);
    check("overrun single pulse", 32'(ovr_n - base), 32'd1);
    for (int i = 1; i <= 4; i++) pop(8'(i), $sformatf("pop 0x0%0d", i));
    check("after overrun empty", 32'(fifo_empty), 32'd1);

    // Reset in the middle of bit 4 of a frame
    send_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bits(1'(8'hA5 >> i), CPB);
    send_bits(1'b0, CPB / 2);
    check("midframe busy", 32'(rx_busy), 32'd1);
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    idle(CPB);
    check("post reset idle", 32'(rx_busy), 32'd0);
    send_frame(8'h7E, 1'b1, 1);
    idle(CPB);
    check("post reset count", 32'(fifo_count), 32'd1);
    pop(8'h7E, "pop 0x7E");
    check("post reset empty", 32'(fifo_empty), 32'd1);

`ifdef RX_MODULE_PARITY_EN
    // Correct parity stored, wrong parity dropped
    base = perr_n;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    par_flip = 1'b0;
    idle(CPB);
    check("parity count", 32'(fifo_count), 32'd1);
    check("parity_err pulses", 32'(perr_n - base), 32'd1);
    pop(8'h07, "pop parity 0x07");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rx_module.md
Name: rx_module

Overview:
- RS232 8N1 receiver: the receive-side counterpart of the design's UART transmit path.
- Runs on the 50 MHz system clock, samples the serial line at mid-bit and writes each accepted byte into an internal FIFO.
- Host logic (the future command/tuning parser) pops bytes with a read request.
- Reports framing errors, FIFO overruns and line activity as status outputs.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); minimum 8
FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 2
SYNC_STAGES, 2, flip-flops in the rx input synchronizer (2 or 3)

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial line; idle high
rd_req  input  1  pop one byte from the FIFO; ignored when fifo_empty
rx_data  output  8  popped byte; valid when rx_valid is high
rx_valid  output  1  one-cycle pulse, one clk after an accepted rd_req
fifo_empty  output  1  FIFO holds no bytes
fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: valid byte dropped because FIFO full
rx_busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async assert, sync release) sets:
  - FSM to IDLE; pointers and count to 0.
  - rx_data=0, rx_valid=0, fifo_empty=1, fifo_full=0, fifo_count=0, frame_err=0, overrun=0, rx_busy=0.
  - Synchronizer flops to 1 (line idle).
- rx passes through SYNC_STAGES flops; the FSM uses only the synchronized value rxs.
- Single bit-timer counter, width $clog2(CLKS_PER_BIT); bit index 0..7; 8-bit shift register.
- FSM states:
  - IDLE: rxs==0 -> START; timer loaded for CLKS_PER_BIT/2 (integer divide).
  - START: at timer expiry sample rxs.
    - 1 -> false start, back to IDLE, nothing written.
    - 0 -> DATA, bit index 0, timer reloaded with CLKS_PER_BIT.
  - DATA: at each expiry shift rxs in, LSB first. After bit 7 -> STOP (or PARITY when the optional feature is on).
  - STOP: at expiry sample rxs.
    - 1 -> byte valid; go to IDLE the same cycle.
    - 0 -> frame_err pulse, byte discarded, go to BREAK.
  - BREAK: wait until rxs==1, then IDLE. Covers line break and stuck-low lines without generating repeated bytes.
- Valid byte: written to FIFO the cycle after the stop sample.
  - If fifo_full at that cycle, byte dropped and overrun pulses.
  - The full check uses pre-read occupancy: a simultaneous rd_req does not rescue the write.
- Read path:
  - rd_req with !fifo_empty -> rx_data registered from head; rx_valid=1 next cycle; head advances.
  - rd_req while empty: no effect, rx_valid stays 0.
  - rx_data holds its last value between reads.
- Simultaneous write and read with FIFO not full and not empty: fifo_count unchanged, both operations performed.
- Pointers wrap modulo FIFO_DEPTH. fifo_full/fifo_empty derive from fifo_count and are registered, consistent with fifo_count every cycle.
- Latency: rx edge to rxs is SYNC_STAGES clk. Byte visible (fifo_empty low) 1 clk after the stop-bit sample point, i.e. about 9.5 bit times after the start edge.
- Reset asserted mid-frame: partial byte lost; after release FSM waits in IDLE for a fresh falling edge. A line still low at release enters START and is validated normally.
- Back-to-back frames: a start edge one cycle after the stop sample is caught; there is no dead time beyond the state transition.

Optional Feature:
- Macro RX_MODULE_PARITY_EN.
- When defined:
  - PARITY state inserted between DATA and STOP; one even-parity bit sampled at mid-bit.
  - Output port parity_err (1 bit) pulses one cycle on mismatch; that byte is discarded and not written.
  - STOP checking is still performed. If both parity and stop fail, both pulses fire in their respective cycles.
- When undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan:
- Send 0x55 then 0xA3 at CLKS_PER_BIT=434 -> fifo_count=2; two rd_req pulses return 0x55 then 0xA3, each with rx_valid one clk later; fifo_empty=1 afterwards.
- 100-clk low glitch on idle rx -> no write, frame_err=0, FSM back to IDLE, rx_busy low within 217+SYNC_STAGES clk.
- Frame 0x3C with stop bit held low for 2 bit times -> single frame_err pulse; FIFO unchanged; no byte written until rx high, then new frame 0x11 received correctly.
- FIFO_DEPTH=4: send 5 bytes 0x01..0x05 without reads -> fifo_full=1 after 4th; overrun pulses once on 5th; reads return 0x01..0x04.
- Assert reset_n low mid-way through bit 4 of a frame, release, then send 0x7E -> only 0x7E in FIFO, fifo_count=1.
- With RX_MODULE_PARITY_EN: send 0x07 with parity bit 1 (correct) then 0x07 with parity bit 0 -> first byte stored, second dropped with one parity_err pulse.
